step_checker: RTL and testbench

- Receiving end of the four-phase one-hot step bus (STEP1..STEP4) that the clock generator drives to sequence the datapath.
- Samples the step lines, acquires lock onto the 1->2->3->4->1 rotation and reports the current phase as a binary index.
- Counts completed instruction cycles and flags sticky sequence and one-hot violations.
- Sits beside the datapath controller as the phase decoder and health monitor.

---
 rtl/step_checker.sv | 137 +++++++++++++
 tb/tb_step_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/step_checker.sv
// Phase decoder and health monitor for the four-phase one-hot step bus.
// Latency: one register stage; every output reflects the sample taken at the same iCLK edge.
// Backpressure: none; a sample is taken every cycle and the block cannot stall the step generator.
module step_checker #(
   parameter int LOCK_STEPS = 4,
   parameter int CNT_W      = 16
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSTEP1,
   input  logic             iSTEP2,
   input  logic             iSTEP3,
   input  logic             iSTEP4,
   input  logic             iCLR_ERR,
   output logic [1:0]       oPHASE,
   output logic             oVALID,
   output logic             oLOCKED,
   output logic             oCYCLE_DONE,
   output logic [CNT_W-1:0] oCYCLES,
   output logic             oERR_SEQ,
   output logic             oERR_ONEHOT
);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_STEPS);

   state_t     stateReg;
   logic [1:0] expIdx;     // expected step as an index: 0 = STEP1 ... 3 = STEP4
   logic [3:0] goodCnt;    // consecutive in-order samples seen while acquiring
   logic [3:0] stepVec;
   logic       stepOneHot;
   logic [1:0] stepIdx;
   logic       stepMatch;

   assign stepVec = {iSTEP4, iSTEP3, iSTEP2, iSTEP1};

   // Classify the raw sample: exactly one line high gives a step index; anything else is illegal.
   always_comb begin
      stepOneHot = 1'b1;
      stepIdx    = 2'd0;
      case (stepVec)
         4'b0001: stepIdx = 2'd0;
         4'b0010: stepIdx = 2'd1;
         4'b0100: stepIdx = 2'd2;
         4'b1000: stepIdx = 2'd3;
         default: stepOneHot = 1'b0;
      endcase
      stepMatch = stepOneHot && (stepIdx == expIdx);
   end

   // Lock FSM with registered phase, cycle counter and sticky error outputs.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         stateReg    <= HUNT;
         expIdx      <= 2'd0;
         goodCnt     <= 4'd0;
         oPHASE      <= 2'd0;
         oVALID      <= 1'b0;
         oLOCKED     <= 1'b0;
         oCYCLE_DONE <= 1'b0;
         oCYCLES     <= '0;
         oERR_SEQ    <= 1'b0;
         oERR_ONEHOT <= 1'b0;
      end else begin
         // Per-edge defaults; an accepted sample in lock overrides them below.
         oPHASE      <= 2'd0;
         oVALID      <= 1'b0;
         oLOCKED     <= 1'b0;
         oCYCLE_DONE <= 1'b0;
         // Clear first so that a set on the same edge (assigned later) wins.
         oERR_SEQ    <= oERR_SEQ    & ~iCLR_ERR;
         oERR_ONEHOT <= oERR_ONEHOT & ~iCLR_ERR;
         case (stateReg)
            HUNT: begin
               if (stepOneHot && stepIdx == 2'd0) begin
                  goodCnt <= 4'd1;
                  expIdx  <= 2'd1;
                  if (LOCK_CNT == 4'd1) begin
                     stateReg <= LOCKED;
                     oLOCKED  <= 1'b1;
                     oVALID   <= 1'b1;
                  end else begin
                     stateReg <= SYNC;
                  end
               end
            end
            SYNC: begin
               if (stepMatch) begin
                  goodCnt <= goodCnt + 4'd1;
                  expIdx  <= expIdx + 2'd1;
                  if (goodCnt + 4'd1 == LOCK_CNT) begin
                     stateReg <= LOCKED;
                     oLOCKED  <= 1'b1;
                     oVALID   <= 1'b1;
                     oPHASE   <= stepIdx;
                     if (stepIdx == 2'd3) begin
                        oCYCLE_DONE <= 1'b1;
                        oCYCLES     <= oCYCLES + CNT_W'(1);
                     end
                  end
               end else begin
                  // Acquisition failures are silent; only a broken lock is an error.
                  stateReg <= HUNT;
                  goodCnt  <= 4'd0;
                  expIdx   <= 2'd0;
               end
            end
            LOCKED: begin
               if (stepMatch) begin
                  expIdx  <= expIdx + 2'd1;
                  oLOCKED <= 1'b1;
                  oVALID  <= 1'b1;
                  oPHASE  <= stepIdx;
                  if (stepIdx == 2'd3) begin
                     oCYCLE_DONE <= 1'b1;
                     oCYCLES     <= oCYCLES + CNT_W'(1);
                  end
               end else begin
                  // The offending sample is dropped, even if it is STEP1.
                  stateReg <= HUNT;
                  goodCnt  <= 4'd0;
                  expIdx   <= 2'd0;
                  if (stepOneHot) oERR_SEQ    <= 1'b1;
                  else            oERR_ONEHOT <= 1'b1;
               end
            end
            default: begin
               stateReg <= HUNT;
               goodCnt  <= 4'd0;
               expIdx   <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_checker.sv
// Directed bench for step_checker: lock, sequence/one-hot errors, error clear, wrap, async reset.
// A second instance with a 2-bit counter shares the stimulus to observe counter wrap.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_step_checker;

   logic        iCLK;
   logic        iRST;
   logic        iSTEP1, iSTEP2, iSTEP3, iSTEP4;
   logic        iCLR_ERR;

   logic [1:0]  phase;
   logic        valid, locked, cycDone, errSeq, errOnehot;
   logic [15:0] cycles;

   logic [1:0]  phaseW;
   logic        validW, lockedW, cycDoneW, errSeqW, errOnehotW;
   logic [1:0]  cyclesW;

   int nChecks = 0;
   int nFails  = 0;

   step_checker #(.LOCK_STEPS(4), .CNT_W(16)) uDut (
      .iCLK(iCLK), .iRST(iRST),
      .iSTEP1(iSTEP1), .iSTEP2(iSTEP2), .iSTEP3(iSTEP3), .iSTEP4(iSTEP4),
      .iCLR_ERR(iCLR_ERR),
      .oPHASE(phase), .oVALID(valid), .oLOCKED(locked), .oCYCLE_DONE(cycDone),
      .oCYCLES(cycles), .oERR_SEQ(errSeq), .oERR_ONEHOT(errOnehot)
   );

   step_checker #(.LOCK_STEPS(4), .CNT_W(2)) uDutW (
      .iCLK(iCLK), .iRST(iRST),
      .iSTEP1(iSTEP1), .iSTEP2(iSTEP2), .iSTEP3(iSTEP3), .iSTEP4(iSTEP4),
      .iCLR_ERR(iCLR_ERR),
      .oPHASE(phaseW), .oVALID(validW), .oLOCKED(lockedW), .oCYCLE_DONE(cycDoneW),
      .oCYCLES(cyclesW), .oERR_SEQ(errSeqW), .oERR_ONEHOT(errOnehotW)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oneHot(input int k);
      logic [3:0] v;
      v = 4'b0001 << (k - 1);
      return v;
   endfunction

   // Apply one sample for one edge; return 1 ns after that edge.
   task automatic drive(input logic [3:0] s, input logic clr);
      {iSTEP4, iSTEP3, iSTEP2, iSTEP1} = s;
      iCLR_ERR = clr;
      @(posedge iCLK);
      #1;
      iCLR_ERR = 1'b0;
   endtask

   task automatic relock();
      for (int k = 1; k <= 4; k++) drive(oneHot(k), 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, "_phase"},  32'(phase),     32'd0);
      checkVal({tag, "_valid"},  32'(valid),     32'd0);
      checkVal({tag, "_locked"}, 32'(locked),    32'd0);
      checkVal({tag, "_done"},   32'(cycDone),   32'd0);
      checkVal({tag, "_cycles"}, 32'(cycles),    32'd0);
      checkVal({tag, "_eseq"},   32'(errSeq),    32'd0);
      checkVal({tag, "_eoh"},    32'(errOnehot), 32'd0);
      checkVal({tag, "_w"}, 32'({phaseW, validW, lockedW, cycDoneW, cyclesW, errSeqW, errOnehotW}), 32'd0);
   endtask

   initial begin
      iRST = 1'b0;
      {iSTEP4, iSTEP3, iSTEP2, iSTEP1} = 4'b0000;
      iCLR_ERR = 1'b0;
      #12;
      checkAllZero("reset");
      iRST = 1'b1;

      // Acquire lock: 0, then 1,2,3,4.
      drive(4'b0000, 1'b0);
      checkVal("hunt_zero_locked", 32'(locked), 32'd0);
      drive(oneHot(1), 1'b0);
      drive(oneHot(2), 1'b0);
      drive(oneHot(3), 1'b0);
      checkVal("sync_locked", 32'(locked), 32'd0);
      checkVal("sync_valid",  32'(valid),  32'd0);
      drive(oneHot(4), 1'b0);
      checkVal("lock_locked", 32'(locked),  32'd1);
      checkVal("lock_valid",  32'(valid),   32'd1);
      checkVal("lock_phase",  32'(phase),   32'd3);
      checkVal("lock_done",   32'(cycDone), 32'd1);
      checkVal("lock_cycles", 32'(cycles),  32'd1);
      checkVal("lock_cyclesW", 32'(cyclesW), 32'd1);

      // Four more rotations: phase 0..3, counter 2..5, narrow counter 2,3,0,1.
      for (int r = 1; r <= 4; r++) begin
         for (int k = 1; k <= 4; k++) begin
            drive(oneHot(k), 1'b0);
            checkVal("rot_phase",  32'(phase),   32'(k - 1));
            checkVal("rot_locked", 32'(locked),  32'd1);
            checkVal("rot_done",   32'(cycDone), (k == 4) ? 32'd1 : 32'd0);
            checkVal("rot_doneW",  32'(cycDoneW), (k == 4) ? 32'd1 : 32'd0);
         end
         checkVal("rot_cycles",  32'(cycles),  32'(r + 1));
         checkVal("rot_cyclesW", 32'(cyclesW), 32'((r + 1) % 4));
      end

      // Skipped step 1,2,4 while locked.
      drive(oneHot(1), 1'b0);
      drive(oneHot(2), 1'b0);
      drive(oneHot(4), 1'b0);
      checkVal("skip_eseq",   32'(errSeq),    32'd1);
      checkVal("skip_eoh",    32'(errOnehot), 32'd0);
      checkVal("skip_locked", 32'(locked),    32'd0);
      checkVal("skip_valid",  32'(valid),     32'd0);
      checkVal("skip_phase",  32'(phase),     32'd0);
      checkVal("skip_done",   32'(cycDone),   32'd0);
      checkVal("skip_cycles", 32'(cycles),    32'd5);
      drive(oneHot(1), 1'b0);
      drive(oneHot(2), 1'b0);
      drive(oneHot(3), 1'b0);
      checkVal("relock_pre", 32'(locked), 32'd0);
      drive(oneHot(4), 1'b0);
      checkVal("relock_locked", 32'(locked),  32'd1);
      checkVal("relock_done",   32'(cycDone), 32'd1);
      checkVal("relock_cycles", 32'(cycles),  32'd6);

      // Multi-hot STEP1+STEP2 while locked.
      drive(4'b0011, 1'b0);
      checkVal("mh_eoh",    32'(errOnehot), 32'd1);
      checkVal("mh_eseq",   32'(errSeq),    32'd1);
      checkVal("mh_locked", 32'(locked),    32'd0);
      relock();
      checkVal("mh_relock_cycles", 32'(cycles), 32'd7);

      // Clear on an accepted in-lock sample: flags drop, lock and count untouched.
      drive(oneHot(1), 1'b1);
      checkVal("clr_eseq",   32'(errSeq),    32'd0);
      checkVal("clr_eoh",    32'(errOnehot), 32'd0);
      checkVal("clr_locked", 32'(locked),    32'd1);
      checkVal("clr_phase",  32'(phase),     32'd0);
      checkVal("clr_cycles", 32'(cycles),    32'd7);

      // All-zero sample while locked.
      drive(4'b0000, 1'b0);
      checkVal("zero_eoh",    32'(errOnehot), 32'd1);
      checkVal("zero_eseq",   32'(errSeq),    32'd0);
      checkVal("zero_locked", 32'(locked),    32'd0);

      // Wrong order sets oERR_SEQ, then a lone clear pulse drops both flags.
      relock();
      drive(oneHot(3), 1'b0);
      checkVal("wo_eseq", 32'(errSeq), 32'd1);
      drive(4'b0000, 1'b1);
      checkVal("clr2_eseq",   32'(errSeq),    32'd0);
      checkVal("clr2_eoh",    32'(errOnehot), 32'd0);
      checkVal("clr2_cycles", 32'(cycles),    32'd8);

      // Clear on the same edge as a new wrong-order sample: set wins.
      relock();
      drive(oneHot(2), 1'b1);
      checkVal("setwins_eseq",   32'(errSeq), 32'd1);
      checkVal("setwins_locked", 32'(locked), 32'd0);
      checkVal("setwins_cycles", 32'(cycles), 32'd9);

      // Asynchronous reset between edges while locked.
      relock();
      checkVal("pre_rst_locked", 32'(locked), 32'd1);
      checkVal("pre_rst_cycles", 32'(cycles), 32'd10);
      #1 iRST = 1'b0;
      #1 checkAllZero("async_rst");
      #1 iRST = 1'b1;
      drive(oneHot(1), 1'b0);
      drive(oneHot(2), 1'b0);
      drive(oneHot(3), 1'b0);
      checkVal("post_rst_locked", 32'(locked),  32'd0);
      checkVal("post_rst_done",   32'(cycDone), 32'd0);
      drive(oneHot(4), 1'b0);
      checkVal("post_rst_lock",   32'(locked),  32'd1);
      checkVal("post_rst_done4",  32'(cycDone), 32'd1);
      checkVal("post_rst_cycles", 32'(cycles),  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
